// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter owning a bank of JK flip-flops.
// Each granted request applies one {j,k} command to one bit, then pulses its ack.
module jk_bank_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [IDX_W-1:0] idx0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [IDX_W-1:0] idx1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               prio_q, prio_d;
    logic               win_q, win_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            op_q    <= '0;
            idx_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        prio_d  = prio_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d   = (req0 && req1) ? prio_q : req1;
                    op_d    = win_d ? op1 : op0;
                    idx_d   = win_d ? idx1 : idx0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                // Out-of-range indices match no iteration, so the bank holds.
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (32'(idx_q) == i) begin
                        unique case (op_q)
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                end
                err_d   = (32'(idx_q) >= WIDTH);
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                prio_d  = ~win_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign busy = (state_q != IDLE);
    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign err  = err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-timestamp model of the bank.
module tb_jk_bank_arbiter;

    localparam int W  = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req [2];
    logic [1:0]    op  [2];
    logic [IW-1:0] idx [2];
    logic          ack0, ack1, err, busy;
    logic [W-1:0]  q, qbar;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req[0]),
        .op0  (op[0]),
        .idx0 (idx[0]),
        .req1 (req[1]),
        .op1  (op[1]),
        .idx1 (idx[1]),
        .ack0 (ack0),
        .ack1 (ack1),
        .err  (err),
        .busy (busy),
        .q    (q),
        .qbar (qbar)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction granted at edge g changes the bank at edge g+1,
    // its ack is visible between g+1 and g+2, and the next grant is possible at g+3.
    logic [W-1:0] mq;
    bit           mprio, have, mw;
    bit           eack0, eack1, eerr, ebusy;
    logic [1:0]   mop;
    int           midx;
    int           g_at;
    int           cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            mq = '0; mprio = 0; have = 0;
            eack0 = 0; eack1 = 0; eerr = 0; ebusy = 0;
        end else begin
            eack0 = 0; eack1 = 0; eerr = 0;
            if (have && cyc == g_at + 1) begin
                if (midx < W) begin
                    case (mop)
                        2'b01:   mq[midx] = 1'b0;
                        2'b10:   mq[midx] = 1'b1;
                        2'b11:   mq[midx] = ~mq[midx];
                        default: ;
                    endcase
                end
                mprio = !mw;
                eack0 = !mw;
                eack1 = mw;
                eerr  = (midx >= W);
            end
            if (!have || cyc >= g_at + 3) begin
                have = 0;
                if (req[0] || req[1]) begin
                    mw   = (req[0] && req[1]) ? mprio : req[1];
                    mop  = op[mw];
                    midx = int'(idx[mw]);
                    g_at = cyc;
                    have = 1;
                end
            end
            ebusy = have && (cyc - g_at) <= 1;
        end
    end

    always @(posedge clk) begin
        logic [W-1:0] nq;
        #1;
        nq = ~mq;
        chk("q",    32'(q),     32'(mq));
        chk("qbar", 32'(qbar),  32'(nq));
        chk("busy", 32'(busy),  32'(ebusy));
        chk("ack0", 32'(ack0),  32'(eack0));
        chk("ack1", 32'(ack1),  32'(eack1));
        chk("err",  32'(err),   32'(eerr));
        chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
    end

    task automatic wait_ack(input int r, output int n);
        bit found = 0;
        n = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            if ((r == 0) ? ack0 : ack1) begin
                found = 1;
                n = k;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ack%0d_timeout: got no ack expected ack within 20 cycles", r);
        end
    endtask

    task automatic single(input int r, input logic [1:0] o, input int i, output int n);
        @(negedge clk);
        req[r] = 1'b1;
        op[r]  = o;
        idx[r] = IW'(i);
        wait_ack(r, n);
        req[r] = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        int who;
        bit got;
        req[0] = 0; req[1] = 0;
        op[0] = 0;  op[1] = 0;
        idx[0] = 0; idx[1] = 0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_q",    32'(q),    32'h00);
        chk("reset_qbar", 32'(qbar), 32'hFF);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_acks", 32'({ack1, ack0}), 32'd0);

        // Single requester: set bit 3, then toggle it back
        single(0, 2'b10, 3, n);
        chk("single_latency", 32'(n), 32'd2);
        @(negedge clk);
        chk("single_set_q", 32'(q), 32'h08);
        single(0, 2'b11, 3, n);
        @(negedge clk);
        chk("single_toggle_q", 32'(q), 32'h00);

        // Contention from reset priority
        reset_pulse();
        @(negedge clk);
        req[0] = 1; op[0] = 2'b10; idx[0] = 0;
        req[1] = 1; op[1] = 2'b10; idx[1] = 7;
        wait_ack(0, n);
        chk("contention_first_not_ack1", 32'(ack1), 32'd0);
        req[0] = 0;
        wait_ack(1, n);
        chk("contention_gap", 32'(n), 32'd3);
        req[1] = 0;
        @(negedge clk);
        chk("contention_q", 32'(q), 32'h81);

        // Round-robin with both requests held high
        @(negedge clk);
        req[0] = 1; op[0] = 2'b11; idx[0] = 1;
        req[1] = 1; op[1] = 2'b11; idx[1] = 2;
        for (int t = 0; t < 4; t++) begin
            got = 0;
            who = -1;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (ack0 || ack1) begin
                    got = 1;
                    who = ack1 ? 1 : 0;
                end
            end
            chk($sformatf("rr_order_%0d", t), 32'(who), 32'(t % 2));
        end
        req[0] = 0; req[1] = 0;
        @(negedge clk);
        chk("rr_q", 32'(q), 32'h81);

        // Out-of-range index
        single(1, 2'b10, 9, n);
        chk("err_with_ack1", 32'({ack1, err}), 32'b11);
        @(negedge clk);
        chk("err_q_unchanged", 32'(q), 32'h81);

        // Reset during APPLY drops the transaction
        @(negedge clk);
        req[0] = 1; op[0] = 2'b10; idx[0] = 4;
        @(negedge clk);
        chk("midop_busy", 32'(busy), 32'd1);
        rst = 0;
        req[0] = 0;
        @(negedge clk);
        chk("midop_q", 32'(q), 32'h00);
        chk("midop_busy_after", 32'(busy), 32'd0);
        rst = 1;
        repeat (3) @(negedge clk);
        single(0, 2'b10, 5, n);
        @(negedge clk);
        chk("resume_q", 32'(q), 32'h20);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) != 0);
            for (int r = 0; r < 2; r++) begin
                if (req[r] && ((r == 0) ? ack0 : ack1)) begin
                    req[r] = 0;
                end else if (!req[r]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req[r] = 1;
                        op[r]  = 2'($urandom_range(0, 3));
                        idx[r] = IW'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    op[r]  = 2'($urandom_range(0, 3));
                    idx[r] = IW'($urandom_range(0, 15));
                end
            end
        end
        @(negedge clk);
        req[0] = 0; req[1] = 0; rst = 1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
